// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch front end.
// Holds the bubble instruction encoding, the opcode field values (inst[6:2])
// used by decode and trace tooling, the fetch FSM state encoding, and the
// layout of the 24-bit decode packet that is handed to the pipeline controller.
package fetch_stage_pkg;

    // addi x0,x0,0 : the canonical bubble word
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Opcode field values as they appear in inst[6:2]
    localparam logic [4:0] OP_R_TYPE = 5'b01100;
    localparam logic [4:0] OP_IMME   = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetchState_t;

    // Decode packet, most significant field first
    typedef struct packed {
        logic       funct7b5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] opcode;
    } dPacket_t;

endpackage

// File: rtl/fetch_stage_inst_packer.sv
// inst_packer: pure bit slicing of a 32-bit RV32I instruction into the
// 24-bit decode packet {inst[30],rs2,rs1,funct3,rd,inst[6:2]}.
// Ports:
//   i_inst    in  32  instruction word
//   o_packet  out 24  packed decode fields
module inst_packer
    import fetch_stage_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [23:0] o_packet
);

    dPacket_t w_packet;

    // Bits 31, 29:25 and 1:0 carry nothing decode needs beyond funct7[5]
    // and the opcode; they are deliberately dropped.
    logic w_unusedBits;
    assign w_unusedBits = ^{i_inst[31], i_inst[29:25], i_inst[1:0]};

    always_comb begin
        w_packet          = '0;
        w_packet.funct7b5 = i_inst[30];
        w_packet.rs2      = i_inst[24:20];
        w_packet.rs1      = i_inst[19:15];
        w_packet.funct3   = i_inst[14:12];
        w_packet.rd       = i_inst[11:7];
        w_packet.opcode   = i_inst[6:2];
    end

    assign o_packet = w_packet;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID register and decode-packet packer for the
// 5-stage RV32I pipeline. One cycle after reset the FSM starts fetching at
// RESET_PC; each accepted word appears on D_inst one cycle later. A redirect
// from execute squashes the D slot; a redirect to a target with bit 1 set
// latches a sticky misalignment trap and freezes fetch until reset.
// Ports:
//   i_clk            in   1   clock
//   i_rst            in   1   asynchronous active-high reset
//   i_stall          in   1   hold PC and IF/ID
//   i_next_pc_sel    in   1   1 = sequential, 0 = redirect to i_jb_pc
//   i_jb_pc          in   32  redirect target
//   o_im_addr        out  32  instruction-memory byte address
//   i_im_rdata       in   32  instruction word at o_im_addr
//   o_D_inst         out  32  IF/ID instruction
//   o_D_pc           out  32  PC of o_D_inst
//   o_D_valid        out  1   o_D_inst is a real instruction
//   o_D_out          out  24  decode packet of o_D_inst
//   o_trap_misalign  out  1   sticky misaligned-target trap
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_next_pc_sel,
    input  logic [31:0] i_jb_pc,
    output logic [31:0] o_im_addr,
    input  logic [31:0] i_im_rdata,
    output logic [31:0] o_D_inst,
    output logic [31:0] o_D_pc,
    output logic        o_D_valid,
    output logic [23:0] o_D_out,
    output logic        o_trap_misalign
);

    fetchState_t r_state;
    logic [31:0] r_pc;
    logic [31:0] r_dInst;
    logic [31:0] r_dPc;
    logic        r_dValid;
    logic        r_trap;

    fetchState_t w_nextState;
    logic [31:0] w_nextPc;
    logic [31:0] w_nextDInst;
    logic [31:0] w_nextDPc;
    logic        w_nextDValid;
    logic        w_nextTrap;

    // Target bit 0 is cleared by JALR semantics, so it never matters here.
    logic w_unusedJbBit;
    assign w_unusedJbBit = i_jb_pc[0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_dInst  <= NOP_INST;
            r_dPc    <= 32'd0;
            r_dValid <= 1'b0;
            r_trap   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_pc     <= w_nextPc;
            r_dInst  <= w_nextDInst;
            r_dPc    <= w_nextDPc;
            r_dValid <= w_nextDValid;
            r_trap   <= w_nextTrap;
        end
    end

    // Redirect outranks stall: an instruction stalled in D during a taken
    // redirect is on the wrong path and must be squashed anyway.
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_nextDInst  = r_dInst;
        w_nextDPc    = r_dPc;
        w_nextDValid = r_dValid;
        w_nextTrap   = r_trap;
        unique case (r_state)
            IDLE: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (!i_next_pc_sel) begin
                    w_nextDInst  = NOP_INST;
                    w_nextDValid = 1'b0;
                    if (i_jb_pc[1]) begin
                        w_nextState = TRAP;
                        w_nextTrap  = 1'b1;
                    end else begin
                        w_nextPc = {i_jb_pc[31:2], 2'b00};
                    end
                end else if (!i_stall) begin
                    w_nextPc     = r_pc + 32'd4;
                    w_nextDInst  = i_im_rdata;
                    w_nextDPc    = r_pc;
                    w_nextDValid = 1'b1;
                end
            end
            TRAP: begin
                w_nextDInst  = NOP_INST;
                w_nextDValid = 1'b0;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    inst_packer u_packer (
        .i_inst   (r_dInst),
        .o_packet (o_D_out)
    );

    assign o_im_addr       = r_pc;
    assign o_D_inst        = r_dInst;
    assign o_D_pc          = r_dPc;
    assign o_D_valid       = r_dValid;
    assign o_trap_misalign = r_trap;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic checked every cycle against
// a behavioural model of the fetch stream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        nextPcSel = 1'b1;
    logic [31:0] jbPc = 32'd0;
    logic [31:0] imAddr;
    logic [31:0] imRdata;
    logic [31:0] dInst;
    logic [31:0] dPc;
    logic        dValid;
    logic [23:0] dOut;
    logic        trapMisalign;

    int assertCount = 0;
    int failCount = 0;
    int memMode = 0;
    bit checkingOn = 1'b0;

    // Model of what the front end must present
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic [31:0] mDPc;
    logic        mValid;
    logic        mTrap;
    bit          mStarted;

    always #5 clk = ~clk;

    // Instruction memory contents, selected per test segment
    function automatic logic [31:0] memWord(input logic [31:0] a, input int mode);
        case (mode)
            0:       return 32'h100 + a;
            1:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
            default: return 32'h00A3_0293;
        endcase
    endfunction

    function automatic logic [23:0] packFields(input logic [31:0] w);
        return {w[30], w[24:20], w[19:15], w[14:12], w[11:7], w[6:2]};
    endfunction

    assign imRdata = memWord(imAddr, memMode);

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_next_pc_sel   (nextPcSel),
        .i_jb_pc         (jbPc),
        .o_im_addr       (imAddr),
        .i_im_rdata      (imRdata),
        .o_D_inst        (dInst),
        .o_D_pc          (dPc),
        .o_D_valid       (dValid),
        .o_D_out         (dOut),
        .o_trap_misalign (trapMisalign)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: one cycle of warm-up after reset, then a trap is
    // absorbing, a redirect discards the decode slot, and otherwise the word
    // at the current fetch address moves to decode unless stalled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPc      = 32'h0;
            mInst    = 32'h13;
            mDPc     = 32'h0;
            mValid   = 1'b0;
            mTrap    = 1'b0;
            mStarted = 1'b0;
        end else if (!mStarted) begin
            mStarted = 1'b1;
        end else if (!mTrap) begin
            if (nextPcSel == 1'b0) begin
                mInst  = 32'h13;
                mValid = 1'b0;
                if (jbPc[1]) mTrap = 1'b1;
                else         mPc   = jbPc & 32'hFFFF_FFFC;
            end else if (!stall) begin
                mInst  = memWord(mPc, memMode);
                mDPc   = mPc;
                mValid = 1'b1;
                mPc    = mPc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checkingOn && !rst) begin
            checkOutput("im_addr", imAddr, mPc);
            checkOutput("D_inst", dInst, mInst);
            checkOutput("D_pc", dPc, mDPc);
            checkOutput("D_valid", {31'd0, dValid}, {31'd0, mValid});
            checkOutput("trap_misalign", {31'd0, trapMisalign}, {31'd0, mTrap});
            checkOutput("D_out", {8'd0, dOut}, {8'd0, packFields(mInst)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sel, input logic [31:0] jb);
        stall = s;
        nextPcSel = sel;
        jbPc = jb;
    endtask

    task automatic applyReset(input int mode);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'd0);
        memMode = mode;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [23:0] expPacket;

    initial begin
        expPacket = {1'b0, 5'd10, 5'd6, 3'd0, 5'd5, 5'd4};
        applyReset(0);
        checkOutput("reset D_out", {8'd0, dOut}, 32'h0000_0004);
        checkOutput("reset D_inst", dInst, 32'h13);
        checkingOn = 1'b1;

        // Sequential fetch
        tick();
        checkOutput("idle D_valid", {31'd0, dValid}, 32'd0);
        checkOutput("idle im_addr", imAddr, 32'h0);
        tick();
        checkOutput("first D_inst", dInst, 32'h100);
        checkOutput("first D_pc", dPc, 32'h0);
        checkOutput("first D_valid", {31'd0, dValid}, 32'd1);
        tick();
        checkOutput("second D_inst", dInst, 32'h104);
        checkOutput("second im_addr", imAddr, 32'h8);

        // Two-cycle stall at 0x8
        applyStimulus(1'b1, 1'b1, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stall im_addr", imAddr, 32'h8);
            checkOutput("stall D_inst", dInst, 32'h104);
            checkOutput("stall D_pc", dPc, 32'h4);
        end
        applyStimulus(1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("resume D_inst", dInst, 32'h108);
        checkOutput("resume im_addr", imAddr, 32'hC);
        tick();
        checkOutput("pre-jump im_addr", imAddr, 32'h10);

        // Redirect to 0x40
        applyStimulus(1'b0, 1'b0, 32'h40);
        tick();
        checkOutput("jump im_addr", imAddr, 32'h40);
        checkOutput("jump D_valid", {31'd0, dValid}, 32'd0);
        checkOutput("jump D_inst", dInst, 32'h13);
        applyStimulus(1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("after jump D_pc", dPc, 32'h40);
        checkOutput("after jump D_inst", dInst, 32'h140);

        // Redirect and stall together: redirect wins
        applyStimulus(1'b1, 1'b0, 32'h20);
        tick();
        checkOutput("jump+stall im_addr", imAddr, 32'h20);
        checkOutput("jump+stall D_valid", {31'd0, dValid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'd0);
        tick();
        checkOutput("jump+stall D_pc", dPc, 32'h20);
        tick();
        tick();
        tick();
        checkOutput("pre-reset im_addr", imAddr, 32'h30);

        // Asynchronous reset in the middle of a stall
        applyStimulus(1'b1, 1'b1, 32'd0);
        tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst im_addr", imAddr, 32'h0);
        checkOutput("async rst D_valid", {31'd0, dValid}, 32'd0);
        checkOutput("async rst D_inst", dInst, 32'h13);
        checkOutput("async rst D_pc", dPc, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'd0);
        tick();
        tick();
        checkOutput("restart D_inst", dInst, 32'h100);

        // Misaligned target 0x22 traps
        applyStimulus(1'b0, 1'b0, 32'h22);
        tick();
        checkOutput("trap flag", {31'd0, trapMisalign}, 32'd1);
        checkOutput("trap im_addr", imAddr, 32'h4);
        checkOutput("trap D_valid", {31'd0, dValid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), $urandom);
            tick();
        end
        checkOutput("trap held im_addr", imAddr, 32'h4);
        checkOutput("trap held flag", {31'd0, trapMisalign}, 32'd1);

        // JALR-style target 0x23 also traps
        applyReset(0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 32'h23);
        tick();
        checkOutput("trap 0x23 flag", {31'd0, trapMisalign}, 32'd1);
        checkOutput("trap 0x23 im_addr", imAddr, 32'h4);

        // Packet field layout on a known word (addi x5,x6,10)
        applyReset(2);
        tick();
        tick();
        checkOutput("packet literal", {8'd0, dOut}, {8'd0, expPacket});

        // Randomized traffic
        applyReset(1);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 9) == 0) ? ($urandom | 32'h2) : ($urandom & 32'hFFFF_FFFD));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
                memMode = $urandom_range(0, 1);
            end else begin
                tick();
            end
        end

        checkingOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
